// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the CPU
// datapath and the program loader; one transaction in flight at a time.
module mem_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [WIDTH-1:0]      cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_done,
    output logic [WIDTH-1:0]      cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [WIDTH-1:0]      ldr_wdata,
    output logic                  ldr_gnt,
    output logic                  ldr_done,
    output logic [WIDTH-1:0]      ldr_rdata,
    input  logic                  ldr_lock,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    output logic                  busy
);
    localparam int CW = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
    typedef enum logic {OWN_CPU = 1'b0, OWN_LDR = 1'b1} own_t;
    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
    } req_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    own_t          owner, last_winner;
    req_t          cap, cpu_r, ldr_r;
    logic          cpu_elig, pick_ldr, start, finish;

    // Locked CPU requests are invisible; a tie goes to whoever lost last time.
    always_comb begin
        cpu_r    = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
        ldr_r    = '{we: ldr_we, addr: ldr_addr, wdata: ldr_wdata};
        cpu_elig = cpu_req & ~ldr_lock;
        pick_ldr = ldr_req & (~cpu_elig | (last_winner == OWN_CPU));
        start    = (state == IDLE) & (cpu_elig | ldr_req);
        finish   = (state == WAIT) & (cnt == CW'(RD_LATENCY));
    end

    always_comb begin
        state_nxt = state;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        unique case (state)
            IDLE:    if (start) state_nxt = ACCESS;
            ACCESS: begin
                state_nxt = WAIT;
                mem_en    = 1'b1;
                mem_we    = cap.we;
            end
            WAIT:    if (finish) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign cpu_gnt   = (state == ACCESS) & (owner == OWN_CPU);
    assign ldr_gnt   = (state == ACCESS) & (owner == OWN_LDR);
    assign mem_addr  = cap.addr;
    assign mem_wdata = cap.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            owner       <= OWN_CPU;
            last_winner <= OWN_LDR;
            cap         <= '0;
            cpu_done    <= 1'b0;
            ldr_done    <= 1'b0;
            cpu_rdata   <= '0;
            ldr_rdata   <= '0;
        end else begin
            state    <= state_nxt;
            cpu_done <= finish & (owner == OWN_CPU);
            ldr_done <= finish & (owner == OWN_LDR);
            if (start) begin
                owner       <= pick_ldr ? OWN_LDR : OWN_CPU;
                last_winner <= pick_ldr ? OWN_LDR : OWN_CPU;
                cap         <= pick_ldr ? ldr_r : cpu_r;
            end
            // cnt numbers the WAIT cycles 1..RD_LATENCY
            if (state == ACCESS)
                cnt <= CW'(1);
            else if (finish)
                cnt <= '0;
            else if (state == WAIT)
                cnt <= cnt + 1'b1;
            if (finish && owner == OWN_CPU) cpu_rdata <= mem_rdata;
            if (finish && owner == OWN_LDR) ldr_rdata <= mem_rdata;
        end
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sequencing one shared single-port synchronous RAM between the multicycle CPU datapath and a program loader (boot/debug port). It captures one request at a time, drives the RAM for one access cycle, waits the RAM read latency, then returns read data with a completion pulse. Ties are broken round-robin. A lock input gives the loader exclusive access during program load.

## Interface
- WIDTH, 32, data word width
- ADDR_WIDTH, 8, word address width
- RD_LATENCY, 1, RAM read latency in cycles (legal range ≥1)

- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU transaction request (level)
- cpu_we  in  1  CPU write enable (1 = write)
- cpu_addr  in  ADDR_WIDTH  CPU word address
- cpu_wdata  in  WIDTH  CPU write data
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted
- cpu_done  out  1  one-cycle pulse: CPU transaction complete
- cpu_rdata  out  WIDTH  CPU read data, valid while cpu_done=1
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  as CPU  loader request signals
- ldr_gnt, ldr_done, ldr_rdata  out  as CPU  loader response signals
- ldr_lock  in  1  1 = CPU requests ignored
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  WIDTH  RAM write data
- mem_rdata  in  WIDTH  RAM read data, valid RD_LATENCY cycles after the mem_en cycle
- busy  out  1  1 when the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE → ACCESS: on the clock edge where state=IDLE and an eligible request exists.
  - ACCESS → WAIT: always.
  - WAIT → WAIT: while the latency counter is below RD_LATENCY.
  - WAIT → IDLE: when the counter reaches RD_LATENCY.
- Eligibility: cpu_req counts only when ldr_lock=0; ldr_req always counts.
- Winner selection:
  - Single eligible requester wins.
  - Both eligible: the requester that did not win last time wins.
  - last_winner resets to LDR, so the CPU wins the first tie.
  - ldr_lock=1 with both requesting: loader wins.
- On the IDLE→ACCESS edge:
  - Winner's we/addr/wdata are captured into internal registers.
  - The winner is recorded in the owner register and in last_winner.
  - The winner's gnt pulses for exactly one cycle (the ACCESS cycle).
- ACCESS cycle:
  - mem_en=1.
  - mem_we = captured we.
  - mem_addr and mem_wdata come from the captured registers.
- All other states: mem_en=0 and mem_we=0. mem_addr and mem_wdata hold their last captured values.
- WAIT → IDLE edge:
  - mem_rdata is captured into the owner's rdata register.
  - Owner's done pulses one cycle (the first IDLE cycle).
  - done also pulses for writes; rdata is then the RAM output and is don't-care.
- rdata registers hold their value until the next completion for that requester.
- Requests are sampled only in IDLE. A req held high through gnt is treated as a new transaction at the next IDLE. Requesters deassert req in the gnt cycle unless they want another access.
- A request arriving while busy waits; req is level-held by the requester, and nothing is queued internally.
- Never both gnt pulses or both done pulses in the same cycle.
- ldr_lock changing mid-transaction does not affect the transaction in flight. It applies at the next IDLE sample.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, last_winner=LDR, owner=CPU.
  - All outputs 0: gnt, done, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - An in-flight transaction is discarded with no done. mem_en drops immediately.
- Cycle numbering: cycle 0 = req high in IDLE.
  - Cycle 1: gnt=1, mem_en=1.
  - Cycles 2..RD_LATENCY+1: WAIT.
  - Cycle RD_LATENCY+2: done=1 with rdata.
- Back-to-back throughput: one transaction per RD_LATENCY+2 cycles. A request high in the done cycle is accepted on that edge.
- busy=1 exactly from the gnt cycle through the last WAIT cycle.
- All outputs are registered or decoded from registered state only. There is no combinational path from req to gnt or mem_*.

## Test plan
- Reset then CPU read (RD_LATENCY=1): cpu_req=1, cpu_addr=0x10, RAM[0x10]=0xDEADBEEF, req dropped at gnt.
  - Expect cpu_gnt in cycle 1, mem_en=1/mem_we=0/mem_addr=0x10 in cycle 1.
  - Expect cpu_done=1 with cpu_rdata=0xDEADBEEF in cycle 3; busy 1 in cycles 1–2.
- Loader write then CPU readback: ldr write 0x1234_5678 to 0x20, then CPU read 0x20.
  - Expect ldr_done in cycle 3.
  - Expect cpu_rdata=0x12345678.
- Simultaneous requests, held continuously for 4 transactions.
  - Expect grant order CPU, LDR, CPU, LDR.
  - Expect gnt spacing 3 cycles (RD_LATENCY=1), never both gnt high.
- ldr_lock=1 with both requesting for 3 transactions.
  - Expect only ldr_gnt.
  - Drop lock: expect next grant to CPU.
- RD_LATENCY=3 build: single CPU read.
  - Expect done in cycle 5 and data sampled after 3 WAIT cycles.
- Reset asserted in WAIT.
  - Expect all outputs 0 immediately and no done.
  - After release: a tie goes to CPU.
